// File: rtl/sprite_dma.sv
// sprite_dma: copies one sprite attribute table (SPR_COUNT x ITEM_BYTES bytes)
// from a CPU-selected source RAM page into sprite RAM, starting only on a
// rising edge of vblank so the sprite engine never sees a half-written table.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   vblank              vertical blank from video timing
//   cpu_wr/cpu_rd       one-cycle register strobes; cpu_addr 0=PAGE, 1=CTRL/STATUS
//   cpu_din/cpu_dout    register write data / registered read data
//   src_*               source RAM read port (data valid one cycle after accept)
//   spriteram_*         sprite RAM write port
//   busy, done_irq      transfer in progress / one-cycle completion pulse
//
// state    | meaning
// IDLE     | nothing armed
// WAIT_VBL | armed, waiting for a vblank rising edge
// READ     | source read requested, held until src_ready
// LATCH    | source data arrives, written to sprite RAM
// CLR      | writing 8'h00, one byte per cycle
// FINISH   | one-cycle completion, raises done / done_irq
module sprite_dma #(
  parameter int SPR_COUNT  = 16,
  parameter int ITEM_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblank,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic        src_ready,
  input  logic [7:0]  src_data,
  output logic [6:0]  spriteram_wr_addr,
  output logic        spriteram_wr,
  output logic [7:0]  spriteram_data_in,
  output logic        busy,
  output logic        done_irq
);

  localparam int N  = SPR_COUNT * ITEM_BYTES;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VBL, S_READ, S_LATCH, S_CLR, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    base_q, base_d;
  logic [7:0]    page_q, page_d;
  logic          auto_q, auto_d;
  logic          clear_q, clear_d;
  logic          armed_q, armed_d;
  logic          done_q, done_d;
  logic          vblank_prev_q, vblank_prev_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic [15:0]   src_addr_q, src_addr_d;
  logic          src_rd_q, src_rd_d;
  logic [6:0]    wr_addr_q, wr_addr_d;
  logic          wr_q, wr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_irq_q, done_irq_d;

  logic ctrl_wr, abort, arm, vbl_rise, unused_din;

  assign ctrl_wr    = cpu_wr && cpu_addr;
  assign abort      = ctrl_wr && cpu_din[7];
  assign arm        = ctrl_wr && cpu_din[0] && !cpu_din[7];
  assign vbl_rise   = vblank && !vblank_prev_q;
  assign unused_din = ^cpu_din[6:3];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    base_d        = base_q;
    page_d        = page_q;
    auto_d        = auto_q;
    clear_d       = clear_q;
    armed_d       = armed_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_d          = 1'b0;
    vblank_prev_d = vblank;

    if (cpu_wr && !cpu_addr) page_d = cpu_din;
    if (ctrl_wr && !cpu_din[7]) begin
      auto_d  = cpu_din[1];
      clear_d = cpu_din[2];
    end
    if (arm) armed_d = 1'b1;

    case (state_q)
      S_IDLE: if (arm) state_d = S_WAIT_VBL;
      S_WAIT_VBL: begin
        if (vbl_rise) begin
          state_d = clear_q ? S_CLR : S_READ;
          idx_d   = '0;
          base_d  = page_q;
          armed_d = arm;
        end
      end
      S_READ: if (src_ready) state_d = S_LATCH;
      S_LATCH, S_CLR: begin
        wr_d      = 1'b1;
        wr_addr_d = 7'(idx_q);
        wr_data_d = (state_q == S_LATCH) ? src_data : 8'h00;
        if (idx_q == LAST) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = (state_q == S_LATCH) ? S_READ : S_CLR;
        end
      end
      S_FINISH: begin
        if (auto_q || armed_q || arm) begin
          state_d = S_WAIT_VBL;
          armed_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      armed_d = 1'b0;
      auto_d  = 1'b0;
      wr_d    = 1'b0;
    end

    // Outputs are registered from the next state so they line up with it.
    src_rd_d   = (state_d == S_READ);
    src_addr_d = src_rd_d ? ({base_d, 8'h00} + 16'(idx_d)) : 16'h0000;
    busy_d     = (state_d == S_READ) || (state_d == S_LATCH) || (state_d == S_CLR);
    done_irq_d = (state_d == S_FINISH);

    // A set in the same cycle as a STATUS read wins over the clear.
    if (done_irq_d)              done_d = 1'b1;
    else if (cpu_rd && cpu_addr) done_d = 1'b0;
    else                         done_d = done_q;

    if (cpu_rd) cpu_dout_d = cpu_addr ? {5'b0, done_q, busy_q, armed_q} : page_q;
    else        cpu_dout_d = cpu_dout_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      base_q        <= 8'h00;
      page_q        <= 8'h00;
      auto_q        <= 1'b0;
      clear_q       <= 1'b0;
      armed_q       <= 1'b0;
      done_q        <= 1'b0;
      vblank_prev_q <= 1'b0;
      cpu_dout_q    <= 8'h00;
      src_addr_q    <= 16'h0000;
      src_rd_q      <= 1'b0;
      wr_addr_q     <= 7'h00;
      wr_q          <= 1'b0;
      wr_data_q     <= 8'h00;
      busy_q        <= 1'b0;
      done_irq_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      base_q        <= base_d;
      page_q        <= page_d;
      auto_q        <= auto_d;
      clear_q       <= clear_d;
      armed_q       <= armed_d;
      done_q        <= done_d;
      vblank_prev_q <= vblank_prev_d;
      cpu_dout_q    <= cpu_dout_d;
      src_addr_q    <= src_addr_d;
      src_rd_q      <= src_rd_d;
      wr_addr_q     <= wr_addr_d;
      wr_q          <= wr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      done_irq_q    <= done_irq_d;
    end
  end

  assign cpu_dout          = cpu_dout_q;
  assign src_addr          = src_addr_q;
  assign src_rd            = src_rd_q;
  assign spriteram_wr_addr = wr_addr_q;
  assign spriteram_wr      = wr_q;
  assign spriteram_data_in = wr_data_q;
  assign busy              = busy_q;
  assign done_irq          = done_irq_q;

endmodule

// File: tb/tb_sprite_dma.sv
// Directed bench for sprite_dma: source RAM and sprite RAM are modelled here,
// every expectation is a hand-derived constant or the bench's own source data.
module tb_sprite_dma;
  logic        clk = 1'b0;
  logic        reset, vblank, cpu_wr, cpu_rd, cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic [15:0] src_addr;
  logic        src_rd, src_ready;
  logic [7:0]  src_data;
  logic [6:0]  spriteram_wr_addr;
  logic        spriteram_wr;
  logic [7:0]  spriteram_data_in;
  logic        busy, done_irq;

  int n_checks = 0;
  int n_fail   = 0;
  int hi_writes = 0;
  int irq_count = 0;
  logic fill_req = 1'b0;
  logic [7:0] sram [0:127];

  always #5 clk = ~clk;

  sprite_dma dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .src_addr(src_addr), .src_rd(src_rd), .src_ready(src_ready), .src_data(src_data),
    .spriteram_wr_addr(spriteram_wr_addr), .spriteram_wr(spriteram_wr),
    .spriteram_data_in(spriteram_data_in),
    .busy(busy), .done_irq(done_irq)
  );

  // Source RAM contents: page 0x12 holds 0x80+i, every other page holds i^0xA5.
  function automatic logic [7:0] src_val(input logic [15:0] a);
    if (a[15:8] == 8'h12) return 8'h80 + a[7:0];
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    src_data <= (src_rd && src_ready) ? src_val(src_addr) : 8'hEE;
    if (fill_req) begin
      for (int i = 0; i < 128; i++) sram[i] <= 8'hFF;
    end else if (spriteram_wr) begin
      sram[spriteram_wr_addr] <= spriteram_data_in;
      if (spriteram_wr_addr[6]) hi_writes <= hi_writes + 1;
    end
    if (done_irq) irq_count <= irq_count + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
    tick;
    cpu_wr = 1'b0; cpu_din = 8'h00;
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] d);
    cpu_rd = 1'b1; cpu_addr = a;
    tick;
    cpu_rd = 1'b0;
    d = cpu_dout;
  endtask

  task automatic fill_ff;
    fill_req = 1'b1;
    tick;
    fill_req = 1'b0;
  endtask

  // n_wr bytes from page (or zeros if clr), everything else still 0xFF.
  task automatic check_ram(input string tag, input logic [7:0] page, input bit clr, input int n_wr);
    logic [7:0] e;
    for (int i = 0; i < 128; i++) begin
      if (i < n_wr) e = clr ? 8'h00 : src_val({page, 8'(i)});
      else          e = 8'hFF;
      check($sformatf("%s ram[%0d]", tag, i), sram[i], e);
    end
  endtask

  // Raises vblank and follows the transfer to done_irq. Cycle 1 is the first
  // cycle after the edge is sampled; pw_cyc > 0 writes PAGE=pw_val then.
  task automatic run_xfer(input string tag, input int exp_cyc, input bit toggle,
                          input logic exp_rd, input logic [15:0] exp_addr,
                          input int pw_cyc, input logic [7:0] pw_val);
    int cyc, busy_cnt;
    bit stalled;
    logic [15:0] held;
    vblank = 1'b1;
    src_ready = toggle ? 1'b0 : 1'b1;
    tick;
    check({tag, " first src_rd"}, src_rd, exp_rd);
    check({tag, " first src_addr"}, src_addr, exp_addr);
    check({tag, " first busy"}, busy, 1'b1);
    cyc = 1; busy_cnt = 0; stalled = 1'b0; held = 16'h0;
    while (!done_irq && cyc < 600) begin
      if (stalled) begin
        check({tag, " stall src_rd"}, src_rd, 1'b1);
        check({tag, " stall src_addr"}, src_addr, held);
      end
      stalled = src_rd && !src_ready;
      held = src_addr;
      if (busy) busy_cnt++;
      if (cyc == 4) vblank = 1'b0;
      if (cyc == pw_cyc) begin
        cpu_wr = 1'b1; cpu_addr = 1'b0; cpu_din = pw_val;
      end else begin
        cpu_wr = 1'b0;
      end
      tick;
      cyc++;
      if (toggle) src_ready = !src_ready;
    end
    cpu_wr = 1'b0;
    check({tag, " done cycle"}, cyc, exp_cyc);
    check({tag, " busy cycles"}, busy_cnt, exp_cyc - 1);
    check({tag, " busy at done"}, busy, 1'b0);
    tick;
    check({tag, " irq one cycle"}, done_irq, 1'b0);
    vblank = 1'b0;
    src_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    int irq0;
    reset = 1'b1; vblank = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 1'b0;
    cpu_din = 8'h00; src_ready = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    check("reset outputs", {cpu_dout, src_addr, src_rd, spriteram_wr_addr, spriteram_wr,
                            spriteram_data_in, busy, done_irq}, 64'h0);
    cpu_read(1'b1, d); check("reset status", d, 8'h00);
    cpu_read(1'b0, d); check("reset page", d, 8'h00);

    // Basic copy; ARM while vblank already high must wait for a fresh edge.
    fill_ff;
    cpu_write(1'b0, 8'h12);
    cpu_read(1'b0, d); check("page readback", d, 8'h12);
    vblank = 1'b1; tick;
    cpu_write(1'b1, 8'h01);
    repeat (4) tick;
    check("no start on high vblank", {busy, src_rd}, 2'b00);
    cpu_read(1'b1, d); check("status armed", d, 8'h01);
    vblank = 1'b0; tick;
    irq0 = irq_count;
    run_xfer("basic", 129, 1'b0, 1'b1, 16'h1200, 0, 8'h00);
    check_ram("basic", 8'h12, 1'b0, 64);
    check("basic irq count", irq_count - irq0, 1);
    cpu_read(1'b1, d); check("status done", d, 8'h04);
    cpu_read(1'b1, d); check("status done cleared", d, 8'h00);

    // Source stalls with src_ready toggling: one stall on byte 0.
    fill_ff;
    cpu_write(1'b1, 8'h01); tick;
    run_xfer("stall", 130, 1'b1, 1'b1, 16'h1200, 0, 8'h00);
    check_ram("stall", 8'h12, 1'b0, 64);
    cpu_read(1'b1, d);

    // CLEAR mode.
    fill_ff;
    cpu_write(1'b1, 8'h05); tick;
    run_xfer("clear", 65, 1'b0, 1'b0, 16'h0000, 0, 8'h00);
    check_ram("clear", 8'h00, 1'b1, 64);
    cpu_write(1'b1, 8'h00);
    cpu_read(1'b1, d);

    // AUTO over three frames, PAGE changed during frame 2.
    fill_ff;
    cpu_write(1'b0, 8'h12);
    cpu_write(1'b1, 8'h03); tick;
    irq0 = irq_count;
    run_xfer("auto f1", 129, 1'b0, 1'b1, 16'h1200, 0, 8'h00);
    check_ram("auto f1", 8'h12, 1'b0, 64);
    cpu_read(1'b1, d); check("auto rearmed", d, 8'h05);
    fill_ff;
    run_xfer("auto f2", 129, 1'b0, 1'b1, 16'h1200, 10, 8'h34);
    check_ram("auto f2", 8'h12, 1'b0, 64);
    cpu_read(1'b0, d); check("auto new page", d, 8'h34);
    fill_ff;
    run_xfer("auto f3", 129, 1'b0, 1'b1, 16'h3400, 0, 8'h00);
    check_ram("auto f3", 8'h34, 1'b0, 64);
    check("auto irq count", irq_count - irq0, 3);
    cpu_write(1'b1, 8'h80); tick;
    cpu_read(1'b1, d); check("after auto abort", d, 8'h04);
    vblank = 1'b1; repeat (3) tick;
    check("aborted auto idle", busy, 1'b0);
    vblank = 1'b0; tick;

    // ABORT (with ARM in the same write) during byte 20.
    fill_ff;
    cpu_write(1'b0, 8'h12);
    cpu_write(1'b1, 8'h01); tick;
    irq0 = irq_count;
    vblank = 1'b1; tick;
    vblank = 1'b0;
    repeat (40) tick;
    check("abort byte20 addr", src_addr, 16'h1214);
    cpu_wr = 1'b1; cpu_addr = 1'b1; cpu_din = 8'h81;
    tick;
    cpu_wr = 1'b0; cpu_din = 8'h00;
    check("abort outputs", {busy, spriteram_wr, src_rd, done_irq}, 4'b0000);
    repeat (150) tick;
    check("abort no irq", irq_count - irq0, 0);
    check_ram("abort", 8'h12, 1'b0, 20);
    cpu_read(1'b1, d); check("abort status", d, 8'h00);

    // Reset during byte 30, then a clean transfer.
    fill_ff;
    cpu_write(1'b1, 8'h01); tick;
    vblank = 1'b1; tick;
    vblank = 1'b0;
    repeat (60) tick;
    reset = 1'b1;
    tick;
    check("midreset outputs", {cpu_dout, src_addr, src_rd, spriteram_wr_addr, spriteram_wr,
                               spriteram_data_in, busy, done_irq}, 64'h0);
    reset = 1'b0;
    tick;
    check("midreset ram29", sram[29], 8'h9D);
    check("midreset ram30", sram[30], 8'hFF);
    cpu_read(1'b1, d); check("midreset status", d, 8'h00);
    cpu_read(1'b0, d); check("midreset page", d, 8'h00);
    fill_ff;
    cpu_write(1'b0, 8'h34);
    cpu_write(1'b1, 8'h01); tick;
    run_xfer("post reset", 129, 1'b0, 1'b1, 16'h3400, 0, 8'h00);
    check_ram("post reset", 8'h34, 1'b0, 64);

    check("no high-half writes", hi_writes, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
